led_blink_arbiter: RTL and testbench
====================================

Name: led_blink_arbiter

Overview:
- Shares one board LED among NUM_REQ status sources: heartbeat, error, activity and so on.
- Each source requests a burst of N blinks. The block arbitrates, times the ON, OFF and GAP phases from the system clock, and acknowledges the requester when its burst has finished.
- Sits between status logic and the LED pad. It replaces free-running blink counters.

Parameters:
- CLOCK_FREQ, 24_000_000, system clock frequency in Hz.
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 4, width of each requester's blink count.
- ON_MS, 200, LED-on time per blink, in ms.
- OFF_MS, 200, LED-off time per blink, in ms.
- GAP_MS, 1000, dark time after the last blink, before ack.

Ports:
- clock, input, 1, system clock; all logic on posedge.
- reset, input, 1, asynchronous, active-high reset.
- req, input, NUM_REQ, request lines; bit i is held high until ack[i].
- req_count, input, NUM_REQ*CNT_W, blink count for requester i at bits [i*CNT_W +: CNT_W].
- ack, output, NUM_REQ, one-cycle completion pulse to the granted requester.
- busy, output, 1, high while a burst is active (any state other than IDLE).
- grant_id, output, clog2(NUM_REQ) (min 1), index of the current owner; 0 when idle.
- led, output, 1, registered LED drive.

Behaviour:
- Reset (async, any state): state=IDLE, led=0, ack=0, busy=0, grant_id=0. All counters are cleared.
- Millisecond tick:
  - Prescaler counts 0..TPM-1, with TPM=CLOCK_FREQ/1000 and width $clog2(TPM).
  - It is cleared on every state entry, so each phase lasts exactly phase_ms*TPM cycles.
- ms counter is 16 bits, cleared on state entry.
- FSM states: IDLE, ON, OFF, GAP, DONE.
- IDLE:
  - If any req bit is high, pick a winner by fixed priority (lowest index wins).
  - Latch grant_id and blinks=req_count[winner].
  - Next cycle: state=ON with led=1, or state=GAP if the count is 0.
  - busy goes high in the same cycle the state leaves IDLE.
- ON: led=1 for ON_MS*TPM cycles, then go to OFF.
- OFF:
  - led=0 for OFF_MS*TPM cycles.
  - Decrement blinks. If the result is 0, go to GAP; otherwise go to ON.
- GAP: led=0 for GAP_MS*TPM cycles, then go to DONE.
- DONE:
  - ack[grant_id]=1 for exactly one cycle; next state IDLE.
  - busy drops when IDLE is entered. grant_id returns to 0.
- Arbitration never happens in the DONE cycle. The next grant is evaluated in IDLE, at least one cycle after ack.
- Abort: if req[grant_id] drops in ON, OFF or GAP, go to IDLE on the next cycle with led=0 and no ack.
- Requests from non-owners are ignored until the block returns to IDLE; there is no preemption.
- Simultaneous req and ack on the same bit in DONE: the ack is honoured. The still-high req is re-arbitrated in IDLE as a new request.
- req_count is sampled only at grant. Later changes have no effect on the current burst.
- led is glitch-free: driven only from a flop.

Optional Feature:
- Macro: LED_BLINK_ARBITER_RR_EN.
- Defined: round-robin arbitration. Search starts at (last grant_id + 1) mod NUM_REQ; the pointer updates in DONE and does not update on abort. Reset pointer is 0.
- Undefined: fixed priority, lowest index wins. No pointer register exists.

Decomposition:
- Shared package/include `led_pkg.vh` holds:
  - FSM state encodings (IDLE=0, ON=1, OFF=2, GAP=3, DONE=4; 3 bits).
  - MS_PER_S=1000.
  - A clog2-safe width macro.
- One sub-module, `ms_tick_gen`: parameter CLOCK_FREQ, inputs clock/reset/clear, output a one-cycle tick every TPM cycles. The FSM and arbiter remain in the top level.

Test Plan:
All tests use CLOCK_FREQ=10_000 (TPM=10), ON_MS=2, OFF_MS=2, GAP_MS=3, NUM_REQ=4.
1. Single burst: req[1]=1, count=3 -> led high for 20 cycles, low for 20, three times; then 30 dark cycles; then ack[1] pulses 1 cycle. Total 151 cycles from the grant.
2. Zero count: req[2]=1, count=0 -> led never rises. ack[2] occurs 31 cycles after the grant.
3. Simultaneous req[0] and req[3] in IDLE -> grant_id=0 first. After ack[0] plus one IDLE cycle, grant_id=3. With RR_EN and last grant 0, a second contention of req 0/3 gives 3.
4. Abort: drop req[1] in the 2nd ON phase -> the next cycle is IDLE with led=0 and busy=0. No ack[1]. A pending req[2] is granted one cycle later.
5. Async reset mid-OFF: assert reset between clock edges -> led, busy, ack and grant_id go to 0 immediately. After release with req held, the burst restarts from ON.
6. req_count changed from 3 to 1 during a burst -> exactly 3 blinks still occur.

Source files
------------

// File: rtl/led_blink_arbiter_pkg.sv
// led_blink_arbiter_pkg: FSM encodings, time base constants and width helper shared by the LED arbiter.
package led_blink_arbiter_pkg;
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ON   = 3'd1,
      ST_OFF  = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } state_t;
   localparam int MS_PER_S = 1000;
   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: one-cycle tick every CLOCK_FREQ/1000 cycles, restartable by clear.
module ms_tick_gen
   import led_blink_arbiter_pkg::*;
#(
   parameter int CLOCK_FREQ = 24_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);
   localparam int TPM = CLOCK_FREQ / MS_PER_S;
   localparam int TW = safe_clog2(TPM);
   logic [TW-1:0] cnt;
   assign tick = (cnt == TW'(TPM - 1));
   always_ff @(posedge clock or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: shares one LED among NUM_REQ sources, each requesting a burst of blinks.
// Define LED_BLINK_ARBITER_RR_EN for round-robin arbitration; default is fixed priority.
module led_blink_arbiter
   import led_blink_arbiter_pkg::*;
#(
   parameter int CLOCK_FREQ = 24_000_000,
   parameter int NUM_REQ = 4,
   parameter int CNT_W = 4,
   parameter int ON_MS = 200,
   parameter int OFF_MS = 200,
   parameter int GAP_MS = 1000,
   localparam int ID_W = safe_clog2(NUM_REQ)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] req_count,
   output logic [NUM_REQ-1:0]       ack,
   output logic                     busy,
   output logic [ID_W-1:0]          grant_id,
   output logic                     led
);
   localparam logic [15:0] ON_L = 16'(ON_MS - 1);
   localparam logic [15:0] OFF_L = 16'(OFF_MS - 1);
   localparam logic [15:0] GAP_L = 16'(GAP_MS - 1);
   state_t state, next;
   logic [CNT_W-1:0] blinks;
   logic [CNT_W-1:0] counts [NUM_REQ];
   logic [15:0] ms_cnt, limit;
   logic [ID_W-1:0] winner, cand, start;
   logic tick, clear, phase_done, owner_req;

   ms_tick_gen #(.CLOCK_FREQ(CLOCK_FREQ)) u_tick (
      .clock(clock),
      .reset(reset),
      .clear(clear),
      .tick (tick)
   );

`ifdef LED_BLINK_ARBITER_RR_EN
   logic [ID_W-1:0] ptr;
   assign start = ptr;
   // Pointer advances only on a completed burst; aborts leave it untouched.
   always_ff @(posedge clock or posedge reset)
      if (reset) ptr <= '0;
      else if (state == ST_DONE) ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
`else
   assign start = '0;
`endif

   always_comb begin
      winner = '0;
      cand = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = ID_W'((int'(start) + i) % NUM_REQ);
         if (req[cand]) winner = cand;
      end
   end

   always_comb
      for (int i = 0; i < NUM_REQ; i++) counts[i] = req_count[i*CNT_W +: CNT_W];

   assign owner_req = req[grant_id];
   assign limit = (state == ST_ON) ? ON_L : (state == ST_OFF) ? OFF_L : GAP_L;
   assign phase_done = tick && (ms_cnt == limit);
   assign clear = (next != state) || (state == ST_IDLE);

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= ST_IDLE;
         led <= 1'b0;
      end else begin
         state <= next;
         led <= (next == ST_ON);
      end

   always_comb begin
      next = state;
      case (state)
         ST_IDLE: next = !(|req) ? ST_IDLE : (counts[winner] == '0) ? ST_GAP : ST_ON;
         ST_ON:   next = !owner_req ? ST_IDLE : phase_done ? ST_OFF : ST_ON;
         ST_OFF:  next = !owner_req ? ST_IDLE : !phase_done ? ST_OFF : (blinks == CNT_W'(1)) ? ST_GAP : ST_ON;
         ST_GAP:  next = !owner_req ? ST_IDLE : phase_done ? ST_DONE : ST_GAP;
         default: next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != ST_IDLE);
      ack = (state == ST_DONE) ? (NUM_REQ'(1) << grant_id) : '0;
   end

   // Count is captured only at grant so later req_count changes cannot alter a burst.
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         grant_id <= '0;
         blinks <= '0;
         ms_cnt <= '0;
      end else begin
         ms_cnt <= clear ? '0 : tick ? ms_cnt + 16'd1 : ms_cnt;
         if (state == ST_IDLE && |req) begin
            grant_id <= winner;
            blinks <= counts[winner];
         end else if (next == ST_IDLE) grant_id <= '0;
         if (state == ST_OFF && phase_done) blinks <= blinks - 1'b1;
      end
endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb_led_blink_arbiter: directed checks of burst timing, arbitration, abort and async reset.
module tb_led_blink_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [3:0] req = '0;
   logic [15:0] req_count = '0;
   logic [3:0] ack;
   logic busy;
   logic [1:0] grant_id;
   logic led;
   int total = 0;
   int bad = 0;

   led_blink_arbiter #(
      .CLOCK_FREQ(10_000),
      .NUM_REQ   (4),
      .CNT_W     (4),
      .ON_MS     (2),
      .OFF_MS    (2),
      .GAP_MS    (3)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req),
      .req_count(req_count),
      .ack      (ack),
      .busy     (busy),
      .grant_id (grant_id),
      .led      (led)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_cnt(input int id, input int c);
      req_count[id*4 +: 4] = 4'(c);
   endtask

   // Full burst from IDLE: cnt blinks of 20/20 cycles, 30 dark, ack at cnt*40+31.
   task automatic burst(input string tag, input int id, input int cnt, input int new_cnt);
      int last;
      logic exp_led;
      last = cnt * 40 + 31;
      set_cnt(id, cnt);
      req = 4'(1 << id);
      for (int n = 1; n <= last; n++) begin
         @(negedge clock);
         exp_led = (n <= cnt * 40) && (((n - 1) / 20) % 2 == 0);
         check({tag, "_led"}, 32'(led), 32'(exp_led));
         check({tag, "_ack"}, 32'(ack), (n == last) ? 32'(1 << id) : 32'd0);
         if (n == 1) check({tag, "_grant"}, 32'(grant_id), 32'(id));
         if (n == 5) set_cnt(id, new_cnt);
      end
      req = '0;
      tick(1);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_grant"}, 32'(grant_id), 32'd0);
   endtask

   initial begin
      req = 4'b1111;
      set_cnt(0, 2);
      tick(2);
      check("rst_led", 32'(led), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      req = '0;
      reset = 1'b0;
      tick(2);
      check("idle_busy", 32'(busy), 32'd0);

      burst("single", 1, 3, 3);
      burst("zero", 2, 0, 0);
      burst("cnt_change", 3, 3, 1);

      set_cnt(0, 1);
      set_cnt(3, 0);
      req = 4'b1001;
      tick(1);
      check("prio_first", 32'(grant_id), 32'd0);
      tick(69);
      check("prio_noack", 32'(ack), 32'd0);
      tick(1);
      check("prio_ack0", 32'(ack), 32'b0001);
      req = 4'b1000;
      tick(1);
      check("prio_gap_grant", 32'(grant_id), 32'd0);
      check("prio_gap_busy", 32'(busy), 32'd0);
      tick(1);
      check("prio_second", 32'(grant_id), 32'd3);
      check("prio_second_busy", 32'(busy), 32'd1);
      tick(30);
      check("prio_ack3", 32'(ack), 32'b1000);
      req = 4'b1001;
      tick(2);
      check("prio_regrant", 32'(grant_id), 32'd0);
      tick(70);
      check("prio_ack0b", 32'(ack), 32'b0001);
      tick(2);
`ifdef LED_BLINK_ARBITER_RR_EN
      check("contend_after0", 32'(grant_id), 32'd3);
`else
      check("contend_after0", 32'(grant_id), 32'd0);
`endif
      req = '0;
      tick(1);
      check("contend_abort_busy", 32'(busy), 32'd0);
      check("contend_abort_ack", 32'(ack), 32'd0);
      tick(1);

      set_cnt(1, 3);
      set_cnt(2, 1);
      req = 4'b0110;
      tick(1);
      check("abort_grant", 32'(grant_id), 32'd1);
      tick(44);
      check("abort_on2_led", 32'(led), 32'd1);
      req = 4'b0100;
      tick(1);
      check("abort_led", 32'(led), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ack", 32'(ack), 32'd0);
      check("abort_gid", 32'(grant_id), 32'd0);
      tick(1);
      check("abort_next_grant", 32'(grant_id), 32'd2);
      check("abort_next_led", 32'(led), 32'd1);
      req = '0;
      tick(2);

      set_cnt(1, 2);
      req = 4'b0010;
      tick(25);
      check("areset_pre_busy", 32'(busy), 32'd1);
      check("areset_pre_led", 32'(led), 32'd0);
      #2 reset = 1'b1;
      #1;
      check("areset_led", 32'(led), 32'd0);
      check("areset_busy", 32'(busy), 32'd0);
      check("areset_grant", 32'(grant_id), 32'd0);
      check("areset_ack", 32'(ack), 32'd0);
      #1 reset = 1'b0;
      tick(1);
      check("areset_restart_led", 32'(led), 32'd1);
      check("areset_restart_grant", 32'(grant_id), 32'd1);
      tick(20);
      check("areset_restart_off", 32'(led), 32'd0);
      req = '0;
      tick(1);
      check("areset_end_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
